// File: rtl/lsq_param_buffer.sv
// In-order load/store queue with CDB wakeup, store commit tracking,
// a valid/ready memory request register and a flush that keeps the
// committed-store run at the head. Entries leave only from the head.
module lsq_param_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ID_W  = 4,
  parameter int OP_W  = 6,
  parameter int NCDB  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    stall,
  input  logic                    enq_valid,
  input  logic                    enq_is_store,
  input  logic [OP_W-1:0]         enq_op,
  input  logic [ID_W-1:0]         enq_id,
  input  logic                    enq_q1_pend,
  input  logic [ID_W-1:0]         enq_q1,
  input  logic [XLEN-1:0]         enq_v1,
  input  logic [XLEN-1:0]         enq_imm,
  input  logic                    enq_q2_pend,
  input  logic [ID_W-1:0]         enq_q2,
  input  logic [XLEN-1:0]         enq_v2,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*ID_W-1:0]    cdb_id,
  input  logic [NCDB*XLEN-1:0]    cdb_data,
  input  logic                    commit_valid,
  input  logic [ID_W-1:0]         commit_id,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_is_store,
  output logic [OP_W-1:0]         mem_req_op,
  output logic [XLEN-1:0]         mem_req_addr,
  output logic [XLEN-1:0]         mem_req_wdata,
  output logic [ID_W-1:0]         mem_req_id,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic            is_store;
    logic            committed;
    logic [OP_W-1:0] op;
    logic [ID_W-1:0] id;
    logic            q1_pend;
    logic [ID_W-1:0] q1;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] imm;
    logic            q2_pend;
    logic [ID_W-1:0] q2;
    logic [XLEN-1:0] v2;
  } entry_t;

  typedef struct packed {
    logic            is_store;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [ID_W-1:0] id;
  } req_t;

  entry_t           ent [DEPTH];
  entry_t           enq_ent;
  entry_t           hd;
  logic [PTR_W-1:0] head, tail, head_n;
  logic [CNT_W-1:0] cnt, cnt_rem, keep;
  logic             enq_fire, pop, head_elig;
  logic [DEPTH-1:0] live, wk1, wk2, cmt;
  logic [XLEN-1:0]  wd1 [DEPTH];
  logic [XLEN-1:0]  wd2 [DEPTH];
  req_t             req;
  logic             req_valid;

  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign enq_fire  = enq_valid && !stall && !flush && !full;
  assign pop       = req_valid && mem_req_ready;
  assign hd        = ent[head];
  assign head_elig = hd.is_store ? (hd.committed && !hd.q1_pend && !hd.q2_pend)
                                 : !hd.q1_pend;

  assign mem_req_valid    = req_valid;
  assign mem_req_is_store = req.is_store;
  assign mem_req_op       = req.op;
  assign mem_req_addr     = req.addr;
  assign mem_req_wdata    = req.wdata;
  assign mem_req_id       = req.id;

  // New entry, snooping the CDB in the same cycle; lowest port wins.
  always_comb begin
    enq_ent           = '0;
    enq_ent.is_store  = enq_is_store;
    enq_ent.op        = enq_op;
    enq_ent.id        = enq_id;
    enq_ent.q1_pend   = enq_q1_pend;
    enq_ent.q1        = enq_q1;
    enq_ent.v1        = enq_v1;
    enq_ent.imm       = enq_imm;
    enq_ent.q2_pend   = enq_is_store && enq_q2_pend;
    enq_ent.q2        = enq_is_store ? enq_q2 : '0;
    enq_ent.v2        = enq_is_store ? enq_v2 : '0;
    for (int k = NCDB-1; k >= 0; k--) begin
      if (cdb_valid[k] && enq_q1_pend && cdb_id[k*ID_W +: ID_W] == enq_q1) begin
        enq_ent.q1_pend = 1'b0;
        enq_ent.v1      = cdb_data[k*XLEN +: XLEN];
      end
      if (cdb_valid[k] && enq_is_store && enq_q2_pend &&
          cdb_id[k*ID_W +: ID_W] == enq_q2) begin
        enq_ent.q2_pend = 1'b0;
        enq_ent.v2      = cdb_data[k*XLEN +: XLEN];
      end
    end
  end

  // Per-slot liveness, CDB wakeup matches (lowest port wins) and commit match.
  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off     = PTR_W'(i) - head;
      live[i] = ({1'b0, off} < cnt);
      wk1[i]  = 1'b0;
      wk2[i]  = 1'b0;
      wd1[i]  = '0;
      wd2[i]  = '0;
      for (int k = NCDB-1; k >= 0; k--) begin
        if (cdb_valid[k] && live[i] && ent[i].q1_pend &&
            cdb_id[k*ID_W +: ID_W] == ent[i].q1) begin
          wk1[i] = 1'b1;
          wd1[i] = cdb_data[k*XLEN +: XLEN];
        end
        if (cdb_valid[k] && live[i] && ent[i].q2_pend &&
            cdb_id[k*ID_W +: ID_W] == ent[i].q2) begin
          wk2[i] = 1'b1;
          wd2[i] = cdb_data[k*XLEN +: XLEN];
        end
      end
      cmt[i] = commit_valid && live[i] && ent[i].is_store && (ent[i].id == commit_id);
    end
  end

  // Flush survivors: committed run starting at the head left after any pop.
  always_comb begin
    logic             run;
    logic [PTR_W-1:0] idx;
    head_n  = head + PTR_W'(pop);
    cnt_rem = cnt - CNT_W'(pop);
    keep    = '0;
    run     = 1'b1;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_n + PTR_W'(k);
      if (run && (CNT_W'(k) < cnt_rem) && ent[idx].committed) keep = keep + CNT_W'(1);
      else run = 1'b0;
    end
  end

  // Entry storage: enqueue writes the tail slot, live slots take wakeups/commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_fire && tail == PTR_W'(i)) begin
          ent[i] <= enq_ent;
        end else begin
          if (wk1[i]) begin
            ent[i].q1_pend <= 1'b0;
            ent[i].v1      <= wd1[i];
          end
          if (wk2[i]) begin
            ent[i].q2_pend <= 1'b0;
            ent[i].v2      <= wd2[i];
          end
          if (cmt[i]) ent[i].committed <= 1'b1;
        end
      end
    end
  end

  // Pointers and occupancy; a flush truncates after the pop is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= head_n;
      tail <= head_n + PTR_W'(keep);
      cnt  <= keep;
    end else begin
      head <= head_n;
      tail <= tail + PTR_W'(enq_fire);
      cnt  <= cnt + CNT_W'(enq_fire) - CNT_W'(pop);
    end
  end

  // Request register: load from an eligible head when idle, hold until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req       <= '0;
    end else if (pop) begin
      req_valid <= 1'b0;
    end else if (flush) begin
      // Only committed stores ever issue, so a store request survives.
      if (!req.is_store) req_valid <= 1'b0;
    end else if (!req_valid && cnt != '0 && head_elig) begin
      req_valid    <= 1'b1;
      req.is_store <= hd.is_store;
      req.op       <= hd.op;
      req.addr     <= hd.v1 + hd.imm;
      req.wdata    <= hd.is_store ? hd.v2 : '0;
      req.id       <= hd.id;
    end
  end

endmodule

// File: tb/tb_lsq_param_buffer.sv
// Scenario bench for lsq_param_buffer (DEPTH=4): expected requests are
// queued when stimulus is driven and compared at each handshake.
module tb_lsq_param_buffer;
  localparam int DEPTH = 4, XLEN = 32, ID_W = 4, OP_W = 6, NCDB = 2;

  typedef struct packed {
    logic        st;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  id;
  } req_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic flush = 0, stall = 0, enq_valid = 0, enq_is_store = 0;
  logic [OP_W-1:0] enq_op = '0;
  logic [ID_W-1:0] enq_id = '0, enq_q1 = '0, enq_q2 = '0, commit_id = '0;
  logic enq_q1_pend = 0, enq_q2_pend = 0, commit_valid = 0, mem_req_ready = 0;
  logic [XLEN-1:0] enq_v1 = '0, enq_imm = '0, enq_v2 = '0;
  logic [NCDB-1:0] cdb_valid = '0;
  logic [NCDB*ID_W-1:0] cdb_id = '0;
  logic [NCDB*XLEN-1:0] cdb_data = '0;
  logic mem_req_valid, mem_req_is_store, full, empty;
  logic [OP_W-1:0] mem_req_op;
  logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
  logic [ID_W-1:0] mem_req_id;
  logic [$clog2(DEPTH):0] count;

  int checks = 0, errors = 0, cyc_cnt = 0;
  req_t sb[$];
  int hs_cyc[$];
  req_t mon_exp, mon_got;

  lsq_param_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_W(ID_W), .OP_W(OP_W), .NCDB(NCDB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .enq_valid(enq_valid), .enq_is_store(enq_is_store), .enq_op(enq_op), .enq_id(enq_id),
    .enq_q1_pend(enq_q1_pend), .enq_q1(enq_q1), .enq_v1(enq_v1), .enq_imm(enq_imm),
    .enq_q2_pend(enq_q2_pend), .enq_q2(enq_q2), .enq_v2(enq_v2),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_id(commit_id),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_is_store(mem_req_is_store), .mem_req_op(mem_req_op),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_id(mem_req_id),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: a handshake happens at the next rising edge whenever valid&ready.
  always begin
    @(negedge clk);
    cyc_cnt++;
    #2;
    if (rst_n && mem_req_valid && mem_req_ready) begin
      hs_cyc.push_back(cyc_cnt);
      mon_got = '{mem_req_is_store, mem_req_op, mem_req_addr, mem_req_wdata, mem_req_id};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req got %h required none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL req_fields got %h required %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_enq(input logic st, input logic [5:0] op, input logic [3:0] id,
                         input logic q1p, input logic [3:0] q1, input logic [31:0] v1,
                         input logic [31:0] imm, input logic q2p, input logic [3:0] q2,
                         input logic [31:0] v2);
    enq_valid = 1; enq_is_store = st; enq_op = op; enq_id = id;
    enq_q1_pend = q1p; enq_q1 = q1; enq_v1 = v1; enq_imm = imm;
    enq_q2_pend = q2p; enq_q2 = q2; enq_v2 = v2;
  endtask

  task automatic wait_empty(input int maxc, input string nm);
    int n = 0;
    while (!(empty && !mem_req_valid && sb.size() == 0) && n < maxc) begin
      cyc();
      n++;
    end
    checks++;
    if (!(empty && !mem_req_valid && sb.size() == 0)) begin
      errors++;
      $display("FAIL %s_drain got empty=%0b valid=%0b pending=%0d required 1 0 0",
               nm, empty, mem_req_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++;
    if ({mem_req_valid, mem_req_is_store, mem_req_op, mem_req_addr, mem_req_wdata,
         mem_req_id, full, empty, count} !== {1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_state got valid=%0b full=%0b empty=%0b count=%0d addr=%h required 0 0 1 0 0",
               mem_req_valid, full, empty, count, mem_req_addr);
    end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_fill_drain();
    mem_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{1'b0, 6'h3, 32'h100 + 32'(4*k), 32'h0, 4'(k)});
      set_enq(0, 6'h3, 4'(k), 0, 0, 32'h100, 32'(4*k), 0, 0, 0);
      cyc();
    end
    enq_valid = 0;
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got full=%0b count=%0d empty=%0b required 1 4 0", full, count, empty);
    end
    set_enq(0, 6'h3, 4'd9, 0, 0, 32'h900, 0, 0, 0, 0);
    cyc();
    enq_valid = 0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL enq_when_full got count=%0d required 4", count);
    end
    hs_cyc.delete();
    mem_req_ready = 1;
    wait_empty(40, "fill");
    checks++;
    if (hs_cyc.size() != 4) begin
      errors++;
      $display("FAIL fill_hs_count got %0d required 4", hs_cyc.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (hs_cyc[k] - hs_cyc[k-1] != 2) begin
          errors++;
          $display("FAIL fill_hs_spacing got %0d required 2", hs_cyc[k] - hs_cyc[k-1]);
        end
      end
    end
    mem_req_ready = 0;
  endtask

  task automatic test_cdb_wakeup();
    mem_req_ready = 0;
    sb.push_back('{1'b0, 6'h3, 32'h2010, 32'h0, 4'd7});
    set_enq(0, 6'h3, 4'd7, 1, 4'd5, 32'h0, 32'h10, 0, 0, 0);
    cyc();
    enq_valid = 0;
    cyc();
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wake_pending got valid=%0b required 0", mem_req_valid);
    end
    cdb_valid = 2'b10; cdb_id = {4'd5, 4'd0}; cdb_data = {32'h2000, 32'h0};
    cyc();
    cdb_valid = '0;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wake_edge got valid=%0b required 0", mem_req_valid);
    end
    cyc();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2010) begin
      errors++;
      $display("FAIL wake_issue got valid=%0b addr=%h required 1 00002010", mem_req_valid, mem_req_addr);
    end
    mem_req_ready = 1;
    wait_empty(10, "wake");
    // Two ports match the same tag: port 0 must win.
    sb.push_back('{1'b0, 6'h3, 32'h300, 32'h0, 4'd8});
    set_enq(0, 6'h3, 4'd8, 1, 4'd6, 32'h0, 32'h0, 0, 0, 0);
    cyc();
    enq_valid = 0;
    cdb_valid = 2'b11; cdb_id = {4'd6, 4'd6}; cdb_data = {32'h400, 32'h300};
    cyc();
    cdb_valid = '0;
    wait_empty(10, "prio");
    // Enqueue-cycle bypass from the CDB.
    sb.push_back('{1'b0, 6'h3, 32'h510, 32'h0, 4'd9});
    set_enq(0, 6'h3, 4'd9, 1, 4'd9, 32'h0, 32'h10, 0, 0, 0);
    cdb_valid = 2'b01; cdb_id = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h500};
    cyc();
    enq_valid = 0; cdb_valid = '0;
    wait_empty(10, "bypass");
    mem_req_ready = 0;
  endtask

  task automatic test_store_commit();
    mem_req_ready = 1;
    sb.push_back('{1'b1, 6'h5, 32'h40, 32'hDEADBEEF, 4'd3});
    set_enq(1, 6'h5, 4'd3, 0, 0, 32'h40, 32'h0, 0, 0, 32'hDEADBEEF);
    cyc();
    enq_valid = 0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL store_nocommit got valid=%0b required 0", mem_req_valid);
      end
      cyc();
    end
    commit_valid = 1; commit_id = 4'd3;
    cyc();
    commit_valid = 0;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_commit_edge got valid=%0b required 0", mem_req_valid);
    end
    cyc();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_is_store !== 1'b1 || mem_req_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_issue got valid=%0b st=%0b wdata=%h required 1 1 deadbeef",
               mem_req_valid, mem_req_is_store, mem_req_wdata);
    end
    wait_empty(10, "store");
    mem_req_ready = 0;
  endtask

  task automatic test_flush();
    mem_req_ready = 0;
    sb.push_back('{1'b1, 6'h5, 32'h80, 32'hCAFE0001, 4'd1});
    set_enq(1, 6'h5, 4'd1, 0, 0, 32'h80, 32'h0, 0, 0, 32'hCAFE0001);
    cyc();
    commit_valid = 1; commit_id = 4'd1;
    set_enq(0, 6'h3, 4'd2, 0, 0, 32'h200, 32'h0, 0, 0, 0);
    cyc();
    commit_valid = 0;
    set_enq(0, 6'h3, 4'd4, 0, 0, 32'h204, 32'h0, 0, 0, 0);
    cyc();
    enq_valid = 0;
    flush = 1;
    cyc();
    flush = 0;
    checks++;
    if (count !== 3'd1 || mem_req_valid !== 1'b1 || mem_req_is_store !== 1'b1) begin
      errors++;
      $display("FAIL flush_keep got count=%0d valid=%0b st=%0b required 1 1 1",
               count, mem_req_valid, mem_req_is_store);
    end
    sb.push_back('{1'b0, 6'h3, 32'h604, 32'h0, 4'd6});
    set_enq(0, 6'h3, 4'd6, 0, 0, 32'h600, 32'h4, 0, 0, 0);
    cyc();
    enq_valid = 0;
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL flush_reenq got count=%0d required 2", count);
    end
    mem_req_ready = 1;
    wait_empty(20, "flush");
    // Outstanding load request is dropped by a flush.
    mem_req_ready = 0;
    set_enq(0, 6'h3, 4'd5, 0, 0, 32'h10, 32'h0, 0, 0, 0);
    cyc();
    enq_valid = 0;
    cyc();
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_load_pre got valid=%0b required 1", mem_req_valid);
    end
    flush = 1;
    cyc();
    flush = 0;
    cyc();
    checks++;
    if (mem_req_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_load_drop got valid=%0b count=%0d empty=%0b required 0 0 1",
               mem_req_valid, count, empty);
    end
  endtask

  task automatic test_hold_stall();
    mem_req_ready = 0;
    sb.push_back('{1'b0, 6'h7, 32'h1020, 32'h0, 4'd10});
    sb.push_back('{1'b0, 6'h7, 32'h1024, 32'h0, 4'd11});
    set_enq(0, 6'h7, 4'd10, 0, 0, 32'h1000, 32'h20, 0, 0, 0);
    cyc();
    set_enq(0, 6'h7, 4'd11, 0, 0, 32'h1000, 32'h24, 0, 0, 0);
    cyc();
    set_enq(0, 6'h7, 4'd12, 0, 0, 32'h1000, 32'h28, 0, 0, 0);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({mem_req_valid, mem_req_is_store, mem_req_op, mem_req_addr, mem_req_wdata, mem_req_id, count}
          !== {1'b1, 1'b0, 6'h7, 32'h1020, 32'h0, 4'd10, 3'd2}) begin
        errors++;
        $display("FAIL hold_stable got valid=%0b addr=%h id=%0d op=%0h count=%0d required 1 00001020 10 7 2",
                 mem_req_valid, mem_req_addr, mem_req_id, mem_req_op, count);
      end
      cyc();
    end
    stall = 0; enq_valid = 0;
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    checks++;
    if (count !== 3'd1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_single_pop got count=%0d valid=%0b required 1 0", count, mem_req_valid);
    end
    mem_req_ready = 1;
    wait_empty(10, "hold");
    mem_req_ready = 0;
  endtask

  task automatic test_async_reset();
    mem_req_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_enq(0, 6'h3, 4'(12 + k), 0, 0, 32'h40, 32'(k), 0, 0, 0);
      cyc();
    end
    enq_valid = 0;
    checks++;
    if (mem_req_valid !== 1'b1 || count !== 3'd3) begin
      errors++;
      $display("FAIL areset_pre got valid=%0b count=%0d required 1 3", mem_req_valid, count);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL areset_async got valid=%0b count=%0d empty=%0b required 0 0 1",
               mem_req_valid, count, empty);
    end
    cyc();
    rst_n = 1;
    cyc(); cyc();
    checks++;
    if (mem_req_valid !== 1'b0 || empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL areset_after got valid=%0b empty=%0b count=%0d required 0 1 0",
               mem_req_valid, empty, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_cdb_wakeup();
    test_store_commit();
    test_flush();
    test_hold_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
